coeff_block_assembler: RTL and testbench

//  Upstream stage of decompress_block. Accepts a serial stream of entropy-decoded
//  (run, level, EOB) symbols and scatters them into an 8x8 coefficient buffer in

---
 rtl/coeff_block_assembler.sv | 159 +++++++++++++++
 tb/tb_coeff_block_assembler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_block_assembler.sv
// -----------------------------------------------------------------------------
// coeff_block_assembler
//
// Collects entropy-decoded (run, level, EOB) symbols into an 8x8 coefficient
// buffer in JPEG zig-zag order. When a block closes, the buffer is presented to
// the downstream decompressor and start_block pulses for one cycle. The buffer
// is then held until the consumer returns block_done.
//
// Block closure: an EOB symbol, a write to the last zig-zag position (63), or a
// run that reaches past position 63 (the level is dropped and overrun_err is
// set). overrun_err is sticky and clears only on reset.
//
// Ports
//   clk               in   rising-edge clock
//   rst               in   asynchronous reset, active high
//   sym_valid         in   symbol valid
//   sym_ready         out  symbol ready (high only while filling)
//   sym_run           in   number of zero positions to skip before the level
//   sym_level         in   signed coefficient value
//   sym_eob           in   end of block; run/level are ignored
//   quantized_coeffs  out  [row][col] registered coefficient buffer
//   start_block       out  one-cycle pulse: buffer holds a complete block
//   block_done        in   consumer finished the block (honoured only in WAIT)
//   overrun_err       out  sticky: a run overran position 63
// -----------------------------------------------------------------------------
module coeff_block_assembler #(
    parameter int BLOCK_SIZE  = 8,  // zig-zag ROM below is defined for 8 only
    parameter int COEFF_WIDTH = 9,
    parameter int RUN_WIDTH   = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    input  logic [RUN_WIDTH-1:0]          sym_run,
    input  logic signed [COEFF_WIDTH-1:0] sym_level,
    input  logic                          sym_eob,
    output logic signed [COEFF_WIDTH-1:0] quantized_coeffs [BLOCK_SIZE][BLOCK_SIZE],
    output logic                          start_block,
    input  logic                          block_done,
    output logic                          overrun_err
);

    // 7 bits hold pos + run (at most 63 + 63) without wrapping.
    localparam int POS_W    = 7;
    localparam int LAST_POS = BLOCK_SIZE * BLOCK_SIZE - 1;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_FILL,
        S_EMIT,
        S_WAIT
    } state_t;

    // Zig-zag position -> raster index (row * 8 + col), standard JPEG order.
    localparam logic [5:0] ZZ_ROM [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    state_t           state;
    state_t           state_nxt;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] target;
    logic             target_over;
    logic             target_last;
    logic [5:0]       raster_idx;
    logic             accept;

    assign accept      = sym_valid && sym_ready;
    assign target      = pos + POS_W'(sym_run);
    assign target_over = target > POS_W'(LAST_POS);
    assign target_last = target == POS_W'(LAST_POS);
    assign raster_idx  = ZZ_ROM[target[5:0]];

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_CLEAR: state_nxt = S_FILL;
            S_FILL: begin
                if (accept && (sym_eob || target_over || target_last)) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: state_nxt = S_WAIT;
            S_WAIT: begin
                if (block_done) begin
                    state_nxt = S_CLEAR;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        sym_ready   = 1'b0;
        start_block = 1'b0;
        unique case (state)
            S_FILL:  sym_ready   = 1'b1;
            S_EMIT:  start_block = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    // NOTE: the coefficient buffer is a register array, not RAM, because it
    // must read as all-zero straight out of reset; that is why it sits in the
    // async reset branch alongside the control flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                for (int c = 0; c < BLOCK_SIZE; c++) begin
                    quantized_coeffs[r][c] <= '0;
                end
            end
            pos         <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (state == S_CLEAR) begin
                for (int r = 0; r < BLOCK_SIZE; r++) begin
                    for (int c = 0; c < BLOCK_SIZE; c++) begin
                        quantized_coeffs[r][c] <= '0;
                    end
                end
                pos <= '0;
            end else if (accept && !sym_eob) begin
                if (target_over) begin
                    // Level has nowhere to go: drop it and flag the stream.
                    overrun_err <= 1'b1;
                end else begin
                    quantized_coeffs[raster_idx[5:3]][raster_idx[2:0]] <= sym_level;
                    pos <= target + POS_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_coeff_block_assembler.sv
// -----------------------------------------------------------------------------
// tb_coeff_block_assembler
//
// Directed bench for coeff_block_assembler. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge. Expected
// coefficient values are written by hand into exp_c before each block check.
// -----------------------------------------------------------------------------
module tb_coeff_block_assembler;

    logic              clk;
    logic              rst;
    logic              sym_valid;
    logic              sym_ready;
    logic [5:0]        sym_run;
    logic signed [8:0] sym_level;
    logic              sym_eob;
    logic signed [8:0] quantized_coeffs [8][8];
    logic              start_block;
    logic              block_done;
    logic              overrun_err;

    int checks;
    int failures;
    int exp_c [8][8];

    coeff_block_assembler #(
        .BLOCK_SIZE (8),
        .COEFF_WIDTH(9),
        .RUN_WIDTH  (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sym_valid       (sym_valid),
        .sym_ready       (sym_ready),
        .sym_run         (sym_run),
        .sym_level       (sym_level),
        .sym_eob         (sym_eob),
        .quantized_coeffs(quantized_coeffs),
        .start_block     (start_block),
        .block_done      (block_done),
        .overrun_err     (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic exp_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp_c[r][c] = 0;
    endtask

    task automatic check_block(input string tag);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                check($sformatf("%s[%0d][%0d]", tag, r, c), int'(quantized_coeffs[r][c]), exp_c[r][c]);
    endtask

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic send_sym(input int run, input int level, input bit eob);
        int waited;
        waited    = 0;
        sym_valid = 1'b1;
        sym_run   = 6'(run);
        sym_level = 9'(level);
        sym_eob   = eob;
        while (!sym_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("send_ready", int'(sym_ready), 1);
        @(negedge clk);
        sym_valid = 1'b0;
        sym_run   = '0;
        sym_level = '0;
        sym_eob   = 1'b0;
    endtask

    // Pulse block_done from WAIT and check the CLEAR -> FILL turnaround.
    task automatic release_block(input string tag);
        block_done = 1'b1;
        @(negedge clk);
        block_done = 1'b0;
        check({tag, "_clear_rdy"}, int'(sym_ready), 0);
        @(negedge clk);
        check({tag, "_fill_rdy"}, int'(sym_ready), 1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        sym_valid  = 1'b0;
        sym_run    = '0;
        sym_level  = '0;
        sym_eob    = 1'b0;
        block_done = 1'b0;

        // 1) reset held, then released
        repeat (3) @(negedge clk);
        exp_clear();
        check("rst_start", int'(start_block), 0);
        check("rst_ready", int'(sym_ready), 0);
        check("rst_ovr", int'(overrun_err), 0);
        check_block("rst");
        rst = 1'b0;
        check("rel_ready_clear", int'(sym_ready), 0);
        @(negedge clk);
        check("rel_ready_fill", int'(sym_ready), 1);
        check("rel_start", int'(start_block), 0);

        // 2) (0,+12), (1,-3), EOB
        send_sym(0, 12, 0);
        send_sym(1, -3, 0);
        check("t2_no_early_start", int'(start_block), 0);
        send_sym(5, 77, 1);
        check("t2_start", int'(start_block), 1);
        check("t2_ready_emit", int'(sym_ready), 0);
        exp_clear();
        exp_c[0][0] = 12;
        exp_c[1][0] = -3;
        check_block("t2");
        @(negedge clk);
        check("t2_start_one_cycle", int'(start_block), 0);
        check("t2_ready_wait", int'(sym_ready), 0);
        // symbols offered during WAIT must not land in the frozen buffer
        sym_valid = 1'b1;
        sym_level = 9'sd99;
        repeat (2) @(negedge clk);
        sym_valid = 1'b0;
        sym_level = '0;
        check("t2_ready_hold", int'(sym_ready), 0);
        check_block("t2_frozen");
        release_block("t2");
        exp_clear();
        check_block("t2_cleared");

        // 3) 64 symbols (0,k), no EOB
        for (int k = 0; k < 64; k++) begin
            send_sym(0, k, 0);
            if (k == 62) begin
                check("t3_open_after_63", int'(sym_ready), 1);
                check("t3_no_start_63", int'(start_block), 0);
            end
        end
        check("t3_start", int'(start_block), 1);
        check("t3_ovr", int'(overrun_err), 0);
        check("t3_00", int'(quantized_coeffs[0][0]), 0);
        check("t3_01", int'(quantized_coeffs[0][1]), 1);
        check("t3_10", int'(quantized_coeffs[1][0]), 2);
        check("t3_20", int'(quantized_coeffs[2][0]), 3);
        check("t3_11", int'(quantized_coeffs[1][1]), 4);
        check("t3_02", int'(quantized_coeffs[0][2]), 5);
        check("t3_07", int'(quantized_coeffs[0][7]), 28);
        check("t3_70", int'(quantized_coeffs[7][0]), 35);
        check("t3_77", int'(quantized_coeffs[7][7]), 63);
        @(negedge clk);
        release_block("t3");

        // 4) (0,5), (63,7): run overruns position 63
        send_sym(0, 5, 0);
        send_sym(63, 7, 0);
        check("t4_start", int'(start_block), 1);
        check("t4_ovr", int'(overrun_err), 1);
        exp_clear();
        exp_c[0][0] = 5;
        check_block("t4");
        @(negedge clk);
        release_block("t4");
        check("t4_ovr_sticky", int'(overrun_err), 1);

        // 5) block A holds [0][0]=9, then block B is EOB only
        send_sym(0, 9, 0);
        send_sym(0, 0, 1);
        check("t5a_start", int'(start_block), 1);
        check("t5a_00", int'(quantized_coeffs[0][0]), 9);
        @(negedge clk);
        release_block("t5a");
        // block_done held across the close and EMIT must not skip WAIT
        block_done = 1'b1;
        send_sym(0, 0, 1);
        check("t5b_start", int'(start_block), 1);
        exp_clear();
        check_block("t5b");
        @(negedge clk);
        block_done = 1'b0;
        check("t5b_wait_ready", int'(sym_ready), 0);
        @(negedge clk);
        check("t5b_wait_ready2", int'(sym_ready), 0);
        release_block("t5b");

        // 6) reset mid-FILL, then mid-WAIT
        send_sym(0, 1, 0);
        send_sym(0, 2, 0);
        send_sym(0, 3, 0);
        rst = 1'b1;
        #1;
        exp_clear();
        check_block("t6_fill_rst");
        check("t6_fill_rst_start", int'(start_block), 0);
        check("t6_fill_rst_ready", int'(sym_ready), 0);
        check("t6_fill_rst_ovr", int'(overrun_err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rec_start", int'(start_block), 0);
        check("t6_rec_ready", int'(sym_ready), 1);
        send_sym(0, 4, 0);
        send_sym(0, 0, 1);
        check("t6_b1_start", int'(start_block), 1);
        check("t6_b1_00", int'(quantized_coeffs[0][0]), 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_block("t6_wait_rst");
        check("t6_wait_rst_start", int'(start_block), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rec2_start", int'(start_block), 0);
        send_sym(2, -7, 0);
        send_sym(0, 0, 1);
        check("t6_b2_start", int'(start_block), 1);
        exp_c[1][0] = -7;
        check_block("t6_b2");
        @(negedge clk);
        release_block("t6_b2");

        // 7) single run landing exactly on position 63 closes without overrun
        send_sym(63, -256, 0);
        check("t7_start", int'(start_block), 1);
        check("t7_ovr", int'(overrun_err), 0);
        exp_clear();
        exp_c[7][7] = -256;
        check_block("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
